// File: rtl/sha256_nonce_ctrl_if.sv
// Work/hit handshake between the host-side work registers, the hash pipes
// and the nonce sequencer.
interface sha256_nonce_ctrl_if #(
    parameter int N_CORES = 2
);
    logic                   start;
    logic                   abort;
    logic [31:0]            nonce_base;
    logic [31:0]            nonce_limit;
    logic [N_CORES*32-1:0]  core_nonce;
    logic                   core_issue;
    logic [N_CORES*32-1:0]  hash_head;
    logic                   busy;
    logic                   done;
    logic                   gn_valid;
    logic [31:0]            gn_nonce;
    logic                   gn_ready;
    logic [7:0]             gn_dropped;

    modport master (
        output start, abort, nonce_base, nonce_limit, hash_head, gn_ready,
        input  core_nonce, core_issue, busy, done, gn_valid, gn_nonce, gn_dropped
    );

    modport slave (
        input  start, abort, nonce_base, nonce_limit, hash_head, gn_ready,
        output core_nonce, core_issue, busy, done, gn_valid, gn_nonce, gn_dropped
    );
endinterface

// File: rtl/sha256_nonce_ctrl.sv
// Nonce sequencer and golden-nonce capture for N_CORES parallel free-running
// double-SHA256 pipelines.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no job; core_issue low, waiting for start
// S_RUN   | issuing one nonce group per cycle until the limit is covered
// S_DRAIN | waiting PIPE_LAT cycles for the final results, done on the last
module sha256_nonce_ctrl #(
    parameter int          N_CORES    = 2,
    parameter int          CORE_BITS  = 1,
    parameter int          PIPE_LAT   = 256,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] MATCH_WORD = 32'ha41f32e7
) (
    input  logic               clk,
    input  logic               rst_n,
    sha256_nonce_ctrl_if.slave bus
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          DW        = $clog2(PIPE_LAT + 1);
    localparam logic [31:0] STEP      = 32'(N_CORES);
    localparam logic [31:0] BASE_MASK = ~((32'd1 << CORE_BITS) - 32'd1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                state;
    logic [31:0]           cnt;
    logic [31:0]           lim;
    logic [31:0]           rcnt;
    logic [31:0]           hit_base;
    logic [N_CORES*32-1:0] nonce_q;
    logic                  issue_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DW-1:0]         drain_cnt;
    logic [PIPE_LAT-1:0]   vld_sr;
    logic [N_CORES-1:0]    hit_q;
    logic [N_CORES-1:0]    hit_next;

    logic [31:0]           fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           fifo_cnt;
    logic [7:0]            dropped_q;

    logic                  restart;
    logic                  last_issue;
    logic                  vld_out;
    logic [31:0]           base_al;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic                  fifo_full;
    logic [31:0]           push_off;
    logic [31:0]           push_nonce;
    logic [4:0]            hit_cnt;
    logic [4:0]            drop_inc;
    logic [8:0]            dropped_sum;
    logic [7:0]            dropped_next;

    assign restart    = bus.start && (state != S_IDLE);
    assign vld_out    = vld_sr[PIPE_LAT-1];
    assign base_al    = bus.nonce_base & BASE_MASK;
    // 33-bit compare so a group ending at 32'hFFFFFFFF is still seen as last
    assign last_issue = ({1'b0, cnt} + 33'(N_CORES - 1)) >= {1'b0, lim};

    always_comb begin
        hit_next = '0;
        for (int k = 0; k < N_CORES; k++) begin
            hit_next[k] = vld_out
                       && (bus.hash_head[k*32 +: 32] == MATCH_WORD)
                       && (({1'b0, rcnt} + 33'(k)) <= {1'b0, lim});
        end
    end

    always_comb begin
        push_req = 1'b0;
        push_off = '0;
        hit_cnt  = '0;
        for (int k = N_CORES - 1; k >= 0; k--) begin
            if (hit_q[k]) begin
                push_req = 1'b1;
                push_off = 32'(k);
            end
        end
        for (int k = 0; k < N_CORES; k++) begin
            hit_cnt = hit_cnt + 5'(hit_q[k]);
        end
    end

    assign push_nonce   = hit_base + push_off;
    assign fifo_full    = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign pop          = (fifo_cnt != '0) && bus.gn_ready;
    assign push_ok      = push_req && (!fifo_full || pop);
    assign drop_inc     = push_req ? (hit_cnt - 5'd1 + 5'(!push_ok)) : 5'd0;
    assign dropped_sum  = {1'b0, dropped_q} + 9'(drop_inc);
    assign dropped_next = dropped_sum[8] ? 8'hFF : dropped_sum[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            lim       <= '0;
            rcnt      <= '0;
            hit_base  <= '0;
            nonce_q   <= '0;
            issue_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            drain_cnt <= '0;
            vld_sr    <= '0;
            hit_q     <= '0;
        end else begin
            done_q   <= 1'b0;
            vld_sr   <= {vld_sr[PIPE_LAT-2:0], issue_q};
            hit_q    <= hit_next;
            hit_base <= rcnt;
            if (vld_out) begin
                rcnt <= rcnt + STEP;
            end
            if (bus.start) begin
                state   <= S_RUN;
                cnt     <= base_al;
                lim     <= bus.nonce_limit;
                rcnt    <= base_al;
                issue_q <= 1'b1;
                busy_q  <= 1'b1;
                for (int k = 0; k < N_CORES; k++) begin
                    nonce_q[k*32 +: 32] <= base_al + 32'(k);
                end
                if (restart) begin
                    vld_sr <= '0;
                    hit_q  <= '0;
                end
            end else if (bus.abort) begin
                state   <= S_IDLE;
                issue_q <= 1'b0;
                busy_q  <= 1'b0;
                vld_sr  <= '0;
                hit_q   <= '0;
            end else begin
                case (state)
                    S_RUN: begin
                        if (last_issue) begin
                            state     <= S_DRAIN;
                            issue_q   <= 1'b0;
                            drain_cnt <= DW'(PIPE_LAT - 1);
                        end else begin
                            cnt <= cnt + STEP;
                            for (int k = 0; k < N_CORES; k++) begin
                                nonce_q[k*32 +: 32] <= cnt + STEP + 32'(k);
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_cnt == '0) begin
                            state  <= S_IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            drain_cnt <= drain_cnt - DW'(1);
                            done_q    <= (drain_cnt == DW'(1));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            dropped_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (restart) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            dropped_q <= '0;
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= push_nonce;
                wr_ptr           <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_cnt  <= fifo_cnt + (AW+1)'(push_ok) - (AW+1)'(pop);
            dropped_q <= dropped_next;
        end
    end

    assign bus.core_nonce = nonce_q;
    assign bus.core_issue = issue_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.gn_valid   = (fifo_cnt != '0);
    assign bus.gn_nonce   = fifo_mem[rd_ptr];
    assign bus.gn_dropped = dropped_q;
endmodule

// File: tb/tb_sha256_nonce_ctrl.sv
// Directed bench for sha256_nonce_ctrl with a small delayed-hash core model.
module tb_sha256_nonce_ctrl;
    localparam int          NC = 2;
    localparam int          PL = 8;
    localparam int          FD = 4;
    localparam logic [31:0] MW = 32'ha41f32e7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sha256_nonce_ctrl_if #(.N_CORES(NC)) bus ();

    sha256_nonce_ctrl #(
        .N_CORES(NC), .CORE_BITS(1), .PIPE_LAT(PL), .FIFO_DEPTH(FD), .MATCH_WORD(MW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Core model: the hash for a nonce issued in cycle c appears in cycle c+PL.
    logic [31:0]        hit_list [8];
    int                 hit_n = 0;
    logic [31:0]        pipe_n [7] = '{default: '0};
    logic [NC*32-1:0]   hash_q = '0;

    function automatic bit is_hit(input logic [31:0] n);
        for (int i = 0; i < 8; i++) begin
            if (i < hit_n && hit_list[i] == n) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        pipe_n[0] <= bus.core_nonce[31:0];
        for (int i = 1; i < 7; i++) pipe_n[i] <= pipe_n[i-1];
        for (int k = 0; k < NC; k++) hash_q[k*32 +: 32] <= is_hit(pipe_n[6] + 32'(k)) ? MW : 32'h0;
    end
    assign bus.hash_head = hash_q;

    logic        obs_issue [64];
    logic        obs_done  [64];
    logic        obs_gv    [64];
    logic        obs_busy  [64];
    logic [31:0] obs_n0    [64];
    logic [31:0] obs_n1    [64];
    logic [31:0] obs_gn    [64];

    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            obs_issue[i] = bus.core_issue;
            obs_done[i]  = bus.done;
            obs_gv[i]    = bus.gn_valid;
            obs_busy[i]  = bus.busy;
            obs_n0[i]    = bus.core_nonce[31:0];
            obs_n1[i]    = bus.core_nonce[63:32];
            obs_gn[i]    = bus.gn_nonce;
            @(negedge clk);
        end
    endtask

    task automatic pulse_start(input logic [31:0] base, input logic [31:0] limit);
        bus.nonce_base  = base;
        bus.nonce_limit = limit;
        bus.start       = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic pop_pulse();
        bus.gn_ready = 1'b1;
        @(negedge clk);
        bus.gn_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++; if ({bus.core_issue, bus.busy, bus.done, bus.gn_valid} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {bus.core_issue, bus.busy, bus.done, bus.gn_valid}); end
        n_checks++; if (bus.core_nonce !== 64'h0) begin n_fail++; $display("FAIL reset_core_nonce: got %h want 0", bus.core_nonce); end
        n_checks++; if (bus.gn_dropped !== 8'h0 || bus.gn_nonce !== 32'h0) begin n_fail++; $display("FAIL reset_gn: got %h/%h want 0/0", bus.gn_dropped, bus.gn_nonce); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.core_issue !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: got busy=%b issue=%b want 0/0", bus.busy, bus.core_issue); end
    endtask

    task automatic test_basic_range();
        int n_iss = 0, last_i = -1, done_i = -1, n_done = 0, bad = 0, gv_seen = 0;
        hit_n = 0;
        pulse_start(32'h100, 32'h10F);
        observe(24);
        for (int i = 0; i < 24; i++) begin
            if (obs_issue[i]) begin
                n_iss++; last_i = i;
                if (obs_n0[i] !== 32'(32'h100 + 2*i) || obs_n1[i] !== 32'(32'h101 + 2*i)) bad++;
            end
            if (obs_done[i]) begin n_done++; done_i = i; end
            if (obs_gv[i]) gv_seen++;
        end
        n_checks++; if (n_iss != 8) begin n_fail++; $display("FAIL basic_issue_count: got %0d want 8", n_iss); end
        n_checks++; if (last_i != 7) begin n_fail++; $display("FAIL basic_last_issue: got %0d want 7", last_i); end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_nonce_values: got %0d bad groups want 0", bad); end
        n_checks++; if (n_done != 1 || done_i != 15) begin n_fail++; $display("FAIL basic_done: got %0d pulses at %0d want 1 at 15", n_done, done_i); end
        n_checks++; if (obs_busy[15] !== 1'b1 || obs_busy[16] !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b%b want 10", obs_busy[15], obs_busy[16]); end
        n_checks++; if (gv_seen != 0) begin n_fail++; $display("FAIL basic_no_hits: got %0d valid cycles want 0", gv_seen); end
        n_checks++; if (obs_n0[20] !== 32'h10E) begin n_fail++; $display("FAIL basic_nonce_hold: got %h want 0000010e", obs_n0[20]); end
    endtask

    task automatic test_single_hit();
        int rise = -1;
        hit_list[0] = 32'h105; hit_n = 1;
        pulse_start(32'h100, 32'h10F);
        observe(24);
        for (int i = 23; i >= 0; i--) if (obs_gv[i]) rise = i;
        n_checks++; if (rise != 12) begin n_fail++; $display("FAIL hit_latency: got rise at %0d want 12", rise); end
        n_checks++; if (obs_gn[12] !== 32'h105) begin n_fail++; $display("FAIL hit_nonce: got %h want 00000105", obs_gn[12]); end
        n_checks++; if (bus.gn_valid !== 1'b1) begin n_fail++; $display("FAIL hit_held: got %b want 1", bus.gn_valid); end
        bus.gn_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.gn_ready = 1'b0;
        n_checks++; if (bus.gn_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pop: got %b want 0", bus.gn_valid); end
        n_checks++; if (bus.gn_dropped !== 8'd0) begin n_fail++; $display("FAIL hit_no_drop: got %0d want 0", bus.gn_dropped); end
    endtask

    task automatic test_collision_and_full();
        logic [31:0] exp_q [4] = '{32'h100, 32'h102, 32'h104, 32'h106};
        hit_list[0] = 32'h108; hit_list[1] = 32'h109; hit_n = 2;
        pulse_start(32'h100, 32'h10F);
        observe(24);
        n_checks++; if (bus.gn_valid !== 1'b1 || bus.gn_nonce !== 32'h108) begin n_fail++; $display("FAIL collide_head: got %b/%h want 1/00000108", bus.gn_valid, bus.gn_nonce); end
        n_checks++; if (bus.gn_dropped !== 8'd1) begin n_fail++; $display("FAIL collide_dropped: got %0d want 1", bus.gn_dropped); end
        pop_pulse();
        n_checks++; if (bus.gn_valid !== 1'b0) begin n_fail++; $display("FAIL collide_single_entry: got %b want 0", bus.gn_valid); end
        hit_list[0] = 32'h100; hit_list[1] = 32'h102; hit_list[2] = 32'h104;
        hit_list[3] = 32'h106; hit_list[4] = 32'h10A; hit_n = 5;
        pulse_start(32'h100, 32'h10F);
        observe(24);
        n_checks++; if (bus.gn_dropped !== 8'd2) begin n_fail++; $display("FAIL full_dropped: got %0d want 2", bus.gn_dropped); end
        for (int j = 0; j < 4; j++) begin
            n_checks++; if (bus.gn_valid !== 1'b1 || bus.gn_nonce !== exp_q[j]) begin n_fail++; $display("FAIL full_order_%0d: got %b/%h want 1/%h", j, bus.gn_valid, bus.gn_nonce, exp_q[j]); end
            pop_pulse();
        end
        n_checks++; if (bus.gn_valid !== 1'b0) begin n_fail++; $display("FAIL full_drained: got %b want 0", bus.gn_valid); end
    endtask

    task automatic test_limit_discard();
        int n_iss = 0, done_i = -1, gv_seen = 0;
        hit_list[0] = 32'h103; hit_n = 1;
        pulse_start(32'h100, 32'h102);
        observe(16);
        for (int i = 0; i < 16; i++) begin
            if (obs_issue[i]) n_iss++;
            if (obs_done[i]) done_i = i;
            if (obs_gv[i]) gv_seen++;
        end
        n_checks++; if (n_iss != 2 || obs_n0[1] !== 32'h102) begin n_fail++; $display("FAIL limit_issue: got %0d groups last %h want 2 last 00000102", n_iss, obs_n0[1]); end
        n_checks++; if (done_i != 9) begin n_fail++; $display("FAIL limit_done: got %0d want 9", done_i); end
        n_checks++; if (gv_seen != 0) begin n_fail++; $display("FAIL limit_discard: got %0d valid cycles want 0", gv_seen); end
        n_checks++; if (bus.gn_dropped !== 8'd2) begin n_fail++; $display("FAIL limit_dropped: got %0d want 2", bus.gn_dropped); end
    endtask

    task automatic test_top_of_range();
        int n_iss = 0, done_i = -1;
        hit_n = 0;
        pulse_start(32'hFFFF_FFFC, 32'hFFFF_FFFF);
        observe(16);
        for (int i = 0; i < 16; i++) begin
            if (obs_issue[i]) n_iss++;
            if (obs_done[i]) done_i = i;
        end
        n_checks++; if (n_iss != 2) begin n_fail++; $display("FAIL wrap_issue_count: got %0d want 2", n_iss); end
        n_checks++; if (obs_n0[0] !== 32'hFFFF_FFFC || obs_n1[1] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_nonces: got %h/%h want fffffffc/ffffffff", obs_n0[0], obs_n1[1]); end
        n_checks++; if (done_i != 9 || obs_busy[10] !== 1'b0) begin n_fail++; $display("FAIL wrap_done: got %0d busy=%b want 9 busy=0", done_i, obs_busy[10]); end
        n_checks++; if (obs_n0[12] !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL wrap_hold: got %h want fffffffe", obs_n0[12]); end
    endtask

    task automatic test_abort();
        int n_done = 0, gv_seen = 0;
        hit_list[0] = 32'h100; hit_n = 1;
        pulse_start(32'h100, 32'h10F);
        repeat (4) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.core_issue !== 1'b0) begin n_fail++; $display("FAIL abort_idle: got busy=%b issue=%b want 0/0", bus.busy, bus.core_issue); end
        observe(12);
        for (int i = 0; i < 12; i++) begin
            if (obs_done[i]) n_done++;
            if (obs_gv[i]) gv_seen++;
        end
        n_checks++; if (n_done != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d want 0", n_done); end
        n_checks++; if (gv_seen != 0) begin n_fail++; $display("FAIL abort_no_push: got %0d valid cycles want 0", gv_seen); end
    endtask

    task automatic test_restart();
        int n_done = 0, done_i = -1;
        hit_list[0] = 32'h102; hit_n = 1;
        pulse_start(32'h100, 32'h10F);
        repeat (13) @(negedge clk);
        n_checks++; if (bus.gn_valid !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL restart_pre: got gv=%b busy=%b want 1/1", bus.gn_valid, bus.busy); end
        pulse_start(32'h200, 32'h20F);
        n_checks++; if (bus.core_issue !== 1'b1 || bus.core_nonce[31:0] !== 32'h200) begin n_fail++; $display("FAIL restart_issue: got %b/%h want 1/00000200", bus.core_issue, bus.core_nonce[31:0]); end
        n_checks++; if (bus.gn_valid !== 1'b0 || bus.gn_dropped !== 8'd0) begin n_fail++; $display("FAIL restart_flush: got gv=%b dropped=%0d want 0/0", bus.gn_valid, bus.gn_dropped); end
        observe(20);
        for (int i = 0; i < 20; i++) if (obs_done[i]) begin n_done++; done_i = i; end
        n_checks++; if (n_done != 1 || done_i != 15) begin n_fail++; $display("FAIL restart_done: got %0d pulses at %0d want 1 at 15", n_done, done_i); end
    endtask

    task automatic test_async_reset();
        hit_list[0] = 32'h100; hit_n = 1;
        pulse_start(32'h100, 32'h13F);
        repeat (12) @(negedge clk);
        n_checks++; if (bus.gn_valid !== 1'b1 || bus.core_issue !== 1'b1) begin n_fail++; $display("FAIL areset_pre: got gv=%b issue=%b want 1/1", bus.gn_valid, bus.core_issue); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({bus.core_issue, bus.busy, bus.done, bus.gn_valid} !== 4'b0 || bus.core_nonce !== 64'h0) begin n_fail++; $display("FAIL areset_ctrl: got %b/%h want 0000/0", {bus.core_issue, bus.busy, bus.done, bus.gn_valid}, bus.core_nonce); end
        n_checks++; if (bus.gn_nonce !== 32'h0 || bus.gn_dropped !== 8'h0) begin n_fail++; $display("FAIL areset_gn: got %h/%h want 0/0", bus.gn_nonce, bus.gn_dropped); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0 || bus.core_issue !== 1'b0) begin n_fail++; $display("FAIL areset_stays_idle: got busy=%b issue=%b want 0/0", bus.busy, bus.core_issue); end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.nonce_base  = '0;
        bus.nonce_limit = '0;
        bus.gn_ready    = 1'b0;
        for (int i = 0; i < 8; i++) hit_list[i] = '0;
        test_reset();
        test_basic_range();
        test_single_hit();
        test_collision_and_full();
        test_limit_discard();
        test_top_of_range();
        test_abort();
        test_restart();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sha256_nonce_ctrl.md
Name: sha256_nonce_ctrl

Overview:
Nonce sequencer and golden-nonce capture for N_CORES parallel free-running double-SHA256 pipelines.
- Issues a distinct nonce to every core each cycle over a programmable inclusive range [nonce_base, nonce_limit].
- Recovers the nonce of each result after PIPE_LAT cycles and compares the core's hash head word against MATCH_WORD.
- Queues hits in a FIFO, so mining continues after a ticket instead of stopping at the first one.
- Sits between the host/UART work registers and the hash pipe instances.

Parameters:
N_CORES, 2, number of hash pipelines; power of two, 1..16.
CORE_BITS, 1, log2(N_CORES); must match N_CORES.
PIPE_LAT, 256, cycles from core_nonce issue to the matching hash_head word at the input.
FIFO_DEPTH, 4, golden-nonce FIFO entries; power of two, at least 2.
MATCH_WORD, 32'ha41f32e7, hash_head value that marks a ticket.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle pulse; latch base/limit and begin a job (restart if already running).
abort  in  1  one-cycle pulse; stop issuing and drop in-flight results.
nonce_base  in  32  first nonce; low CORE_BITS are ignored and treated as 0.
nonce_limit  in  32  last nonce to report, inclusive.
core_nonce  out  N_CORES*32  slice k = nonce for core k this cycle.
core_issue  out  1  core_nonce is a live issue this cycle.
hash_head  in  N_CORES*32  slice k = first word of core k's second hash.
busy  out  1  high in RUN or DRAIN.
done  out  1  one-cycle pulse when the range has been fully issued and drained.
gn_valid  out  1  FIFO not empty.
gn_nonce  out  32  nonce at the FIFO head.
gn_ready  in  1  pop the FIFO when gn_valid and gn_ready are both high.
gn_dropped  out  8  saturating count of hits lost to a full FIFO or to same-cycle collisions.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, FIFO empty, valid history cleared.
- FSM states are IDLE, RUN and DRAIN.
- IDLE -> RUN on start. The start cycle registers the inputs: cnt = {nonce_base[31:CORE_BITS], 0}, lim = nonce_limit.
- RUN, issue:
  - First issue is the cycle after start, with core_issue = 1.
  - core_nonce slice k = cnt + k.
  - cnt advances by N_CORES every cycle.
- RUN, last issue: the cycle where cnt + N_CORES - 1 >= lim, computed at 33 bits so the compare cannot wrap. cnt = 32'hFFFFFFF0 with N_CORES = 16 is also a last issue.
- RUN -> DRAIN after the last issue cycle.
  - DRAIN holds core_issue = 0 for PIPE_LAT cycles, then pulses done for 1 cycle and returns to IDLE.
  - core_nonce holds its last value while core_issue = 0.
- Result tracking:
  - A PIPE_LAT-deep shift register carries core_issue.
  - A result counter rcnt loads the latched base at start and advances by N_CORES on each cycle where the shift-register output is high.
- Hit detection:
  - Core k hits when hash_head slice k == MATCH_WORD, the shift output is high, and rcnt + k <= lim.
  - Hits from nonces above lim in the final group are discarded and not counted.
  - Hit flags and nonces are registered once; the FIFO push happens the next cycle.
  - Total latency: issue at cycle c, push at c+PIPE_LAT+1, gn_valid high at c+PIPE_LAT+2.
- Same-cycle hits: the lowest core index is pushed; each other hit increments gn_dropped.
- FIFO full: push while full with no pop in the same cycle drops the entry and increments gn_dropped. Push and pop in the same cycle while full succeeds.
- FIFO pop: while gn_valid is high, gn_nonce is the head entry; it is removed at the edge where gn_valid and gn_ready are both high. gn_ready while empty is ignored.
- start while in RUN or DRAIN (restart):
  - Relatches base and limit and re-enters RUN.
  - Clears the valid shift register and flushes the FIFO; gn_dropped resets to 0.
  - No done pulse for the abandoned job.
- abort:
  - Goes to IDLE the next cycle and clears the valid shift register, so no further hits are pushed.
  - FIFO contents are kept and no done pulse is produced.
  - If start and abort arrive together, start wins.
- A hash_head match while the shift output is low is ignored.
- Asserting rst_n low at any point returns every register to its reset value immediately.

Test Plan:
1. N_CORES=2, PIPE_LAT=8, base=0x100, limit=0x10F, no hits -> 8 issue cycles (core0 0x100, 0x102 … 0x10E); done pulses 8 cycles after the last issue; gn_valid stays 0.
2. Same range; drive MATCH_WORD on core1 8 cycles after core_nonce = 0x104 -> gn_valid rises 2 cycles later with gn_nonce = 0x105; pop with gn_ready -> gn_valid = 0.
3. Both cores hit in the same cycle at rcnt = 0x108 -> FIFO holds 0x108 only, gn_dropped = 1; 5 hits with gn_ready = 0 and FIFO_DEPTH=4 -> 4 entries held, gn_dropped increments by 1.
4. base=0x100, limit=0x102 -> 2 issue groups; a hit on nonce 0x103 is discarded and the FIFO and gn_dropped are unchanged.
5. base=0xFFFFFFFC, limit=0xFFFFFFFF -> 2 issue cycles then DRAIN and done, with no wrap to nonce 0.
6. abort mid-RUN with an in-flight hit -> no push, busy = 0 next cycle, no done; start during DRAIN -> FIFO flushed, new base issued the cycle after start; rst_n low mid-RUN -> all outputs 0 asynchronously.
